// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the gray-to-Sobel stage: window shift timing, trailing pad, border flags.
// Optional macro SOBEL_FRAME_AUTO_EN: DONE rolls straight into the next frame without start.
module sobel_frame_ctrl #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 720,
    parameter int CW     = $clog2(WIDTH*HEIGHT+WIDTH+2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_empty,
    output logic                      in_rd_en,
    output logic                      shift_en,
    output logic                      pad_sel,
    input  logic                      out_afull,
    output logic                      out_wr_en,
    output logic                      border,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int COLW = $clog2(WIDTH);
    localparam int ROWW = $clog2(HEIGHT);

    localparam logic [CW-1:0]   LAST_PIX   = CW'(WIDTH*HEIGHT-1);
    localparam logic [CW-1:0]   LAST_SHIFT = CW'(WIDTH*HEIGHT+WIDTH);
    localparam logic [CW-1:0]   FIRST_OUT  = CW'(WIDTH+1);
    localparam logic [COLW-1:0] COL_LAST   = COLW'(WIDTH-1);
    localparam logic [ROWW-1:0] ROW_LAST   = ROWW'(HEIGHT-1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   shift_cnt_q, shift_cnt_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic            out_wr_en_q, out_wr_en_d;

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        shift_en    = 1'b0;
        in_rd_en    = 1'b0;
        pad_sel     = 1'b0;

        // Coordinates track the push that is landing this cycle.
        if (out_wr_en_q) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    shift_cnt_d = '0;
                    col_d       = '0;
                    row_d       = '0;
                end
            end
            RUN: begin
                shift_en = !in_empty && !out_afull;
                in_rd_en = shift_en;
                if (shift_en) begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == LAST_PIX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                shift_en = !out_afull;
                pad_sel  = 1'b1;
                if (shift_en) begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == LAST_SHIFT) state_d = FLUSH;
                end
            end
            FLUSH: state_d = DONE;
            DONE: begin
`ifdef SOBEL_FRAME_AUTO_EN
                state_d     = RUN;
                shift_cnt_d = '0;
                col_d       = '0;
                row_d       = '0;
`else
                state_d     = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // The first WIDTH+1 shifts only prime the window; no centre pixel exists yet.
        out_wr_en_d = shift_en && (shift_cnt_q >= FIRST_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_cnt_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_wr_en_q <= out_wr_en_d;
        end
    end

    assign out_wr_en  = out_wr_en_q;
    assign out_col    = col_q;
    assign out_row    = row_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    // Gated by out_wr_en so the flag stays low outside pushes and during reset.
    assign border     = out_wr_en_q &&
                        (row_q == '0 || row_q == ROW_LAST || col_q == '0 || col_q == COL_LAST);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl at WIDTH=4, HEIGHT=3: vector table plus coordinate scoreboard.
module tb_sobel_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int COLW = $clog2(W);
    localparam int ROWW = $clog2(H);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            in_empty = 1'b1;
    logic            out_afull = 1'b0;
    logic            in_rd_en, shift_en, pad_sel, out_wr_en, border, busy, frame_done;
    logic [COLW-1:0] out_col;
    logic [ROWW-1:0] out_row;

    sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .shift_en   (shift_en),
        .pad_sel    (pad_sel),
        .out_afull  (out_afull),
        .out_wr_en  (out_wr_en),
        .border     (border),
        .out_col    (out_col),
        .out_row    (out_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int col;
        int row;
        bit brd;
    } coord_t;
    coord_t sbq[$];

    typedef struct {
        bit s, e, a;
        bit shift, rd, pad, wr, bsy, done;
    } vec_t;
    localparam int NV = 20;
    vec_t tbl[NV];

    // Reference model state: 0 idle, 1 run, 2 drain, 3 flush, 4 done
    int m_phase = 0;
    int m_shift = 0;
    bit m_wr = 1'b0;

    int n_shift, n_pop, n_push, n_done, n_inner, n_idle;
    bit r_shift, r_rd, r_pad, r_wr, r_busy, r_done;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_shift_en"}, shift_en, 0);
        chk({tag, "_in_rd_en"}, in_rd_en, 0);
        chk({tag, "_pad_sel"}, pad_sel, 0);
        chk({tag, "_out_wr_en"}, out_wr_en, 0);
        chk({tag, "_border"}, border, 0);
        chk({tag, "_out_col"}, out_col, 0);
        chk({tag, "_out_row"}, out_row, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic clear_tallies();
        n_shift = 0; n_pop = 0; n_push = 0; n_done = 0; n_inner = 0; n_idle = 0;
    endtask

    // One clock: drive, sample at negedge, check against the model, advance the model.
    task automatic cycle(input bit s, input bit e, input bit a);
        bit x_shift;
        coord_t c;
        start = s; in_empty = e; out_afull = a;
        @(negedge clk);
        x_shift = (m_phase == 1) ? (!e && !a) : (m_phase == 2) ? !a : 1'b0;
        chk("shift_en", shift_en, x_shift);
        chk("in_rd_en", in_rd_en, (m_phase == 1) && x_shift);
        chk("pad_sel", pad_sel, m_phase == 2);
        chk("busy", busy, m_phase != 0);
        chk("frame_done", frame_done, m_phase == 4);
        chk("out_wr_en", out_wr_en, m_wr);
        if (out_wr_en) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL push_unexpected: got push at col=%0d row=%0d expected none", out_col, out_row);
            end else begin
                c = sbq.pop_front();
                chk("out_col", out_col, c.col);
                chk("out_row", out_row, c.row);
                chk("border", border, c.brd);
            end
        end
        r_shift = shift_en; r_rd = in_rd_en; r_pad = pad_sel; r_wr = out_wr_en;
        r_busy = busy; r_done = frame_done;
        n_shift += int'(shift_en); n_pop += int'(in_rd_en); n_push += int'(out_wr_en);
        n_done += int'(frame_done); n_idle += int'(!busy);
        if (out_wr_en && !border) n_inner++;

        m_wr = x_shift && (m_shift >= W + 1);
        if (m_wr) begin
            c.col = (m_shift - W - 1) % W;
            c.row = (m_shift - W - 1) / W;
            c.brd = (c.row == 0) || (c.row == H - 1) || (c.col == 0) || (c.col == W - 1);
            sbq.push_back(c);
        end
        case (m_phase)
            0: if (s) begin m_phase = 1; m_shift = 0; end
            1: if (x_shift) begin if (m_shift == W*H - 1) m_phase = 2; m_shift++; end
            2: if (x_shift) begin if (m_shift == W*H + W) m_phase = 3; m_shift++; end
            3: m_phase = 4;
            4: begin
`ifdef SOBEL_FRAME_AUTO_EN
                m_phase = 1; m_shift = 0;
`else
                m_phase = 0;
`endif
            end
            default: m_phase = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        start = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero(tag);
        @(posedge clk);
        #1 rst = 1'b0;
        m_phase = 0; m_shift = 0; m_wr = 1'b0;
        sbq.delete();
    endtask

    task automatic run_frames(input int frames, input int stall_after, input int stall_len,
                              input int afull_len, input int extra_start_at);
        int cyc = 0;
        int stalled = 0;
        int held = 0;
        bit e, a, s;
        clear_tallies();
        s = 1'b1;
        while (n_done < frames && cyc < 400) begin
            e = 1'b0;
            a = 1'b0;
            if (stall_len > 0 && n_pop >= stall_after && stalled < stall_len) begin
                e = 1'b1; stalled++;
            end
            if (afull_len > 0 && m_phase == 2 && held < afull_len) begin
                a = 1'b1; held++;
            end
            if (cyc == extra_start_at) s = 1'b1;
            cycle(s, e, a);
            s = 1'b0;
            cyc++;
        end
        if (n_done < frames) begin
            total++; bad++;
            $display("FAIL frame_timeout: got %0d frame_done pulses expected %0d", n_done, frames);
        end
        chk("total_pops", n_pop, 12 * frames);
        chk("total_pushes", n_push, 12 * frames);
        chk("total_shifts", n_shift, 17 * frames);
        chk("inner_pushes", n_inner, 2 * frames);
        chk("frame_done_count", n_done, frames);
        chk("scoreboard_left", sbq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            tbl[i].s     = (i == 0);
            tbl[i].e     = 1'b0;
            tbl[i].a     = 1'b0;
            tbl[i].shift = (i >= 1 && i <= 17);
            tbl[i].rd    = (i >= 1 && i <= 12);
            tbl[i].pad   = (i >= 13 && i <= 17);
            tbl[i].wr    = (i >= 7 && i <= 18);
            tbl[i].bsy   = (i >= 1);
            tbl[i].done  = (i == 19);
        end

        #3 chk_all_zero("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Clean frame against the fixed cycle table
        clear_tallies();
        for (int i = 0; i < NV; i++) begin
            cycle(tbl[i].s, tbl[i].e, tbl[i].a);
            chk($sformatf("tbl%0d_shift", i), r_shift, tbl[i].shift);
            chk($sformatf("tbl%0d_rd", i), r_rd, tbl[i].rd);
            chk($sformatf("tbl%0d_pad", i), r_pad, tbl[i].pad);
            chk($sformatf("tbl%0d_wr", i), r_wr, tbl[i].wr);
            chk($sformatf("tbl%0d_busy", i), r_busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i), r_done, tbl[i].done);
        end
        chk("tbl_shifts", n_shift, 17);
        chk("tbl_pops", n_pop, 12);
        chk("tbl_pushes", n_push, 12);
        chk("tbl_inner", n_inner, 2);
        chk("tbl_done", n_done, 1);

        // Abort mid-RUN, then a clean frame
        do_reset("rst_a");
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0);
        do_reset("rst_mid");
        run_frames(1, 0, 0, 0, -1);

        do_reset("rst_b");
        run_frames(1, 7, 10, 0, -1);

        do_reset("rst_c");
        run_frames(1, 0, 0, 8, -1);

        do_reset("rst_d");
        run_frames(1, 0, 0, 0, 3);
`ifndef SOBEL_FRAME_AUTO_EN
        clear_tallies();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("idle_no_restart", n_shift, 0);
        chk("idle_busy_low", n_idle, 5);
`endif

`ifdef SOBEL_FRAME_AUTO_EN
        do_reset("rst_e");
        run_frames(2, 0, 0, 0, -1);
        chk("auto_idle_cycles", n_idle, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
- Frame sequencer for the grayscale-to-Sobel stage of top_level.
- Sits between the gray pixel FIFO (FWFT) and the 3x3 window/line-buffer datapath, and between the Sobel result and the 8-bit output FIFO.
- Decides when the window shifts, pads the trailing W+1 positions after the last real pixel, marks border results, and announces frame completion.
- Contains no pixel data path; all pixel data stays in the datapath.

Parameters:
- WIDTH, 720: pixels per row.
- HEIGHT, 720: rows per frame.
- CW, $clog2(WIDTH*HEIGHT+WIDTH+2): shift/position counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame from IDLE.
- in_empty  in  1  gray FIFO empty.
- in_rd_en  out  1  pop gray FIFO.
- shift_en  out  1  advance window and line buffers by one pixel.
- pad_sel  out  1  datapath shifts 8'h00 instead of FIFO data.
- out_afull  in  1  output FIFO has at most 1 free slot.
- out_wr_en  out  1  push current Sobel result.
- border  out  1  datapath forces pushed value to 8'h00; valid with out_wr_en.
- out_col  out  $clog2(WIDTH)  column of the pixel being pushed.
- out_row  out  $clog2(HEIGHT)  row of the pixel being pushed.
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse after the last push.

Behaviour:
- Reset is asynchronous, active-high. All outputs are 0 and all counters are 0 while rst is high; state is IDLE.
- State IDLE:
  - busy=0.
  - start=1 clears shift_cnt, out_col and out_row, then moves to RUN.
- State RUN:
  - shift_en = !in_empty && !out_afull.
  - in_rd_en = shift_en; pad_sel=0.
  - On a shift with shift_cnt == WIDTH*HEIGHT-1, move to DRAIN.
- State DRAIN:
  - shift_en = !out_afull; in_rd_en=0; pad_sel=1.
  - On a shift with shift_cnt == WIDTH*HEIGHT+WIDTH, move to FLUSH.
- State FLUSH: one cycle, then DONE. This lets the last registered out_wr_en land.
- State DONE: frame_done=1 for one cycle, then IDLE.
- shift_cnt increments on every shift_en. Total shifts per frame = WIDTH*HEIGHT+WIDTH+1.
- Window centre lags the newest shifted pixel by WIDTH+1 positions.
- out_wr_en is registered: out_wr_en(t+1) = shift_en(t) && shift_cnt(t) >= WIDTH+1. This gives exactly WIDTH*HEIGHT pushes per frame, with latency of 1 cycle from the qualifying shift.
- out_afull is used (not full) because one push is always in flight when the next shift is decided.
- out_col/out_row:
  - Present the coordinates of the pixel being pushed.
  - After each push, out_col increments, wrapping WIDTH-1 -> 0 and incrementing out_row.
  - out_row never exceeds HEIGHT-1 within a frame.
- border = (out_row==0 || out_row==HEIGHT-1 || out_col==0 || out_col==WIDTH-1), evaluated combinationally from out_row/out_col and meaningful only while out_wr_en=1.
  - Stale line-buffer contents from a previous or aborted frame therefore never reach the output.
- start while busy is ignored.
- in_empty and out_afull both asserted: no shift, all counters hold.
- The FIFO may go empty mid-RUN; this stalls the frame with no data loss.
- rst mid-frame aborts immediately. The controller does not clear the FIFOs or line buffers; border forcing covers the stale data.

Optional Feature:
- Macro: SOBEL_FRAME_AUTO_EN.
- When defined:
  - DONE moves directly to RUN, clearing the counters, with no start needed.
  - start from IDLE still launches the first frame.
  - frame_done still pulses every frame, and busy stays 1 between frames.
- When undefined: DONE moves to IDLE and each frame needs a start pulse.

Test Plan:
- Reset: rst=1 mid-RUN (WIDTH=4, HEIGHT=3) -> all outputs 0 at once, without waiting for a clock edge; IDLE; start afterwards runs a clean frame.
- Full frame, WIDTH=4, HEIGHT=3, FIFO always non-empty, out_afull=0:
  - exactly 17 shift_en cycles;
  - in_rd_en on the first 12 only, pad_sel on the last 5;
  - 12 out_wr_en pushes, the first one cycle after the 6th shift;
  - border=0 only at (col,row)=(1,1) and (2,1);
  - frame_done one cycle after FLUSH.
- Input stall: hold in_empty=1 for 10 cycles after 7 pops -> no shift and no push during the stall; totals still 12 pops and 12 pushes.
- Backpressure: assert out_afull for 8 cycles during DRAIN -> shift_en=0 during those cycles; no push lost or duplicated; coordinates continuous.
- start while busy: pulse start in RUN -> ignored; exactly one frame_done.
- SOBEL_FRAME_AUTO_EN defined: one start -> two consecutive frames, 24 pushes total, two frame_done pulses, busy never drops between frames.
